sixteen_bit_lookahead_adder: RTL and testbench

16-bit two-level carry-lookahead adder with registered outputs. It computes S = A + B + C_in and the carry-out. It is a datapath arithmetic primitive used wherever a fast 16-bit add with carry-in and carry-out is needed. Adder logic is combinational; the result is captured on one clock edge.

---
 rtl/sixteen_bit_lookahead_adder.sv | 83 ++++++++
 tb/tb_sixteen_bit_lookahead_adder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sixteen_bit_lookahead_adder.sv
`default_nettype none
// ============================================================================
// Module   : sixteen_bit_lookahead_adder
// Purpose  : 16-bit two-level carry-lookahead adder with registered sum/carry.
// Revision : 1.0 - initial release
// ============================================================================
module sixteen_bit_lookahead_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] S,
  output logic        C_out
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [15:0] w_sum;
  logic [3:0]  w_grp_g;
  logic [3:0]  w_grp_p;
  logic [4:0]  w_blk_c;   // carries into each block; [4] is the carry-out

  logic [15:0] r_s;
  logic        r_cout;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // First level: each nibble resolves its internal carries in parallel
  generate
    for (genvar k = 0; k < 4; k++) begin : g_blk
      logic [3:0] w_bg;
      logic [3:0] w_bp;
      logic       w_ci;

      assign w_bg = w_g[4*k +: 4];
      assign w_bp = w_p[4*k +: 4];
      assign w_ci = w_blk_c[k];

      assign w_c[4*k]   = w_ci;
      assign w_c[4*k+1] = w_bg[0] | (w_bp[0] & w_ci);
      assign w_c[4*k+2] = w_bg[1] | (w_bp[1] & w_bg[0]) | (w_bp[1] & w_bp[0] & w_ci);
      assign w_c[4*k+3] = w_bg[2] | (w_bp[2] & w_bg[1]) | (w_bp[2] & w_bp[1] & w_bg[0])
                        | (w_bp[2] & w_bp[1] & w_bp[0] & w_ci);

      assign w_grp_p[k] = &w_bp;
      assign w_grp_g[k] = w_bg[3] | (w_bp[3] & w_bg[2]) | (w_bp[3] & w_bp[2] & w_bg[1])
                        | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0]);
    end
  endgenerate

  // Second level: block carry-ins computed directly from group G/P
  assign w_blk_c[0] = C_in;
  assign w_blk_c[1] = w_grp_g[0] | (w_grp_p[0] & C_in);
  assign w_blk_c[2] = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[1] & w_grp_p[0] & C_in);
  assign w_blk_c[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1])
                    | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & C_in);
  assign w_blk_c[4] = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                    | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & C_in);

  assign w_sum = w_p ^ w_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= 16'h0000;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_blk_c[4];
    end
  end

  assign S     = r_s;
  assign C_out = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_sixteen_bit_lookahead_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sixteen_bit_lookahead_adder
// Purpose  : Self-checking bench: directed vector table, reset sequences, random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sixteen_bit_lookahead_adder;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        C_in;
  logic [15:0] S;
  logic        C_out;

  int n_tests;
  int n_fail;

  sixteen_bit_lookahead_adder dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .S     (S),
    .C_out (C_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [15:0] exp_s, input logic exp_c);
    n_tests++;
    if (S !== exp_s || C_out !== exp_c) begin
      n_fail++;
      $display("FAIL %s: got S=%h C_out=%b, expected S=%h C_out=%b",
               name, S, C_out, exp_s, exp_c);
    end
  endtask

  // Drive one operand set, clock it, then sample away from the edge
  task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                      input logic ci);
    rst  = r;
    A    = a;
    B    = b;
    C_in = ci;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci);
    return {1'b0, a} + {1'b0, b} + {16'b0, ci};
  endfunction

  initial begin
    logic [16:0] exp;
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{16'hF0F1, 16'hCA3F, 1'b0, 16'hBB30, 1'b1};
    vecs[1]  = '{16'h9C9D, 16'h8FF0, 1'b0, 16'h2C8D, 1'b1};
    vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1};
    vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4]  = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0};
    vecs[5]  = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
    vecs[6]  = '{16'h009D, 16'h800F, 1'b0, 16'h80AC, 1'b0};
    vecs[7]  = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0};
    vecs[8]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    vecs[9]  = '{16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0};
    vecs[10] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[11] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

    // Reset wins over all-ones operands
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    check("reset_cycle0", 16'h0000, 1'b0);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    check("reset_cycle1", 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0);
    check("first_after_reset", 16'h0000, 1'b0);

    for (int i = 0; i < 12; i++) begin
      step(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("vec%0d", i), vecs[i].s, vecs[i].cout);
    end

    // Mid-stream reset discards the pending result, next edge is valid again
    step(1'b0, 16'h1234, 16'h4321, 1'b1);
    check("pre_reset", 16'h5556, 1'b0);
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    check("mid_reset", 16'h0000, 1'b0);
    step(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    check("post_reset", 16'h0000, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      logic        r;
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      r  = ($urandom_range(0, 49) == 0);
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      exp = r ? 17'h0 : ref_sum(a, b, ci);
      step(r, a, b, ci);
      check(r ? "rand_reset" : "rand", exp[15:0], exp[16]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
